// File: rtl/my_axi4_lite_mst_if.sv
// AXI4-Lite bundle shared by the master block and whatever slave it talks to.
// Both widths are parameters so one definition serves 32- and 64-bit buses.
interface axi4_lite_if #(
  parameter int ADDR_BIT_WIDTH = 4,
  parameter int DATA_BIT_WIDTH = 32
);
  logic [ADDR_BIT_WIDTH-1:0]   awaddr;
  logic [2:0]                  awprot;
  logic                        awvalid;
  logic                        awready;
  logic [DATA_BIT_WIDTH-1:0]   wdata;
  logic [DATA_BIT_WIDTH/8-1:0] wstrb;
  logic                        wvalid;
  logic                        wready;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;
  logic [ADDR_BIT_WIDTH-1:0]   araddr;
  logic [2:0]                  arprot;
  logic                        arvalid;
  logic                        arready;
  logic [DATA_BIT_WIDTH-1:0]   rdata;
  logic [1:0]                  rresp;
  logic                        rvalid;
  logic                        rready;

  modport mst_port (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slv_port (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/my_axi4_lite_mst.sv
// Single-outstanding AXI4-Lite master: turns a valid/ready command into one
// AXI write or read and hands the slave's response back on a valid/ready port.
module my_axi4_lite_mst #(
  parameter int ADDR_BIT_WIDTH = 4,
  parameter int DATA_BIT_WIDTH = 32
) (
  input  logic                        i_clk,
  input  logic                        i_async_rst_n,
  input  logic                        i_cmd_valid,
  output logic                        o_cmd_ready,
  input  logic                        i_cmd_we,
  input  logic [ADDR_BIT_WIDTH-1:0]   i_cmd_addr,
  input  logic [DATA_BIT_WIDTH-1:0]   i_cmd_wdata,
  input  logic [DATA_BIT_WIDTH/8-1:0] i_cmd_wstrb,
  output logic                        o_rsp_valid,
  input  logic                        i_rsp_ready,
  output logic                        o_rsp_is_wr,
  output logic [DATA_BIT_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]                  o_rsp_resp,
  axi4_lite_if.mst_port               if_m_axi4_lite
);
  localparam int STRB_W = DATA_BIT_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_RSP
  } state_e;

  state_e                    state_q, state_d;
  logic [1:0]                rst_sync_q;
  logic [ADDR_BIT_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_BIT_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]         wstrb_q, wstrb_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      bready_q, bready_d;
  logic                      arvalid_q, arvalid_d;
  logic                      rready_q, rready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_is_wr_q, rsp_is_wr_d;
  logic [DATA_BIT_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                rsp_resp_q, rsp_resp_d;

  // Reset asserts asynchronously everywhere, but the release only reaches the
  // command port after two clean edges, so no command is taken mid-release.
  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign o_cmd_ready = (state_q == S_IDLE) && rst_sync_q[1];

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_is_wr_d = rsp_is_wr_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid && o_cmd_ready) begin
          addr_d = i_cmd_addr;
          if (i_cmd_we) begin
            wdata_d   = i_cmd_wdata;
            wstrb_d   = i_cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
          end
        end
      end
      S_WR: begin
        // AW and W retire independently; move on once neither is pending.
        if (awvalid_q && if_m_axi4_lite.awready) awvalid_d = 1'b0;
        if (wvalid_q && if_m_axi4_lite.wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (if_m_axi4_lite.bvalid && bready_q) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_is_wr_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = if_m_axi4_lite.bresp;
          state_d     = S_RSP;
        end
      end
      S_RD_ADDR: begin
        if (arvalid_q && if_m_axi4_lite.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (if_m_axi4_lite.rvalid && rready_q) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_is_wr_d = 1'b0;
          rsp_rdata_d = if_m_axi4_lite.rdata;
          rsp_resp_d  = if_m_axi4_lite.rresp;
          state_d     = S_RSP;
        end
      end
      S_RSP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_is_wr_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_is_wr_q <= rsp_is_wr_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign if_m_axi4_lite.awaddr  = addr_q;
  assign if_m_axi4_lite.awprot  = 3'b000;
  assign if_m_axi4_lite.awvalid = awvalid_q;
  assign if_m_axi4_lite.wdata   = wdata_q;
  assign if_m_axi4_lite.wstrb   = wstrb_q;
  assign if_m_axi4_lite.wvalid  = wvalid_q;
  assign if_m_axi4_lite.bready  = bready_q;
  assign if_m_axi4_lite.araddr  = addr_q;
  assign if_m_axi4_lite.arprot  = 3'b000;
  assign if_m_axi4_lite.arvalid = arvalid_q;
  assign if_m_axi4_lite.rready  = rready_q;

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_is_wr = rsp_is_wr_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_resp  = rsp_resp_q;
endmodule

// File: tb/tb_my_axi4_lite_mst.sv
// Bench for my_axi4_lite_mst: a memory-backed AXI4-Lite slave with random
// ready/valid delays, a word-array reference model and a protocol monitor.
module tb_my_axi4_lite_mst;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_is_wr;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;

  int n_chk = 0;
  int n_err = 0;

  axi4_lite_if #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW)) axi ();

  my_axi4_lite_mst #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW)) dut (
    .i_clk          (clk),
    .i_async_rst_n  (rst_n),
    .i_cmd_valid    (cmd_valid),
    .o_cmd_ready    (cmd_ready),
    .i_cmd_we       (cmd_we),
    .i_cmd_addr     (cmd_addr),
    .i_cmd_wdata    (cmd_wdata),
    .i_cmd_wstrb    (cmd_wstrb),
    .o_rsp_valid    (rsp_valid),
    .i_rsp_ready    (rsp_ready),
    .o_rsp_is_wr    (rsp_is_wr),
    .o_rsp_rdata    (rsp_rdata),
    .o_rsp_resp     (rsp_resp),
    .if_m_axi4_lite (axi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Slave configuration, slave memory and the reference word array.
  int          aw_dly, w_dly, ar_dly, b_dly, r_dly;
  logic [1:0]  bresp_cfg, rresp_cfg;
  logic [31:0] smem [4];
  logic [31:0] ref_mem [4];

  // Handshake counters and captured payloads, updated at each rising edge.
  int            aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0;
  logic [AW-1:0] aw_addr_c, ar_addr_c;
  logic [31:0]   w_data_c;
  logic [3:0]    w_strb_c;

  // Rising-edge monitor: counts handshakes and checks VALID/payload holding.
  initial begin
    logic p_rst, p_aw_v, p_aw_hs, p_w_v, p_w_hs, p_ar_v, p_ar_hs, p_b_hs, p_r_hs;
    logic p_rsp_v, p_rsp_rdy, p_rsp_wr;
    logic [AW-1:0] p_aw_addr, p_ar_addr;
    logic [31:0] p_w_data, p_rsp_data;
    logic [1:0] p_rsp_resp;
    p_rst = 1'b0;
    forever begin
      @(posedge clk);
      if (rst_n && p_rst) begin
        if (p_aw_hs) chk("aw_drop", 64'(axi.awvalid), 64'd0);
        else if (p_aw_v) chk("aw_hold", 64'({axi.awvalid, axi.awaddr}), 64'({1'b1, p_aw_addr}));
        if (p_w_hs) chk("w_drop", 64'(axi.wvalid), 64'd0);
        else if (p_w_v) chk("w_hold", 64'({axi.wvalid, axi.wdata}), 64'({1'b1, p_w_data}));
        if (p_ar_hs) chk("ar_drop", 64'(axi.arvalid), 64'd0);
        else if (p_ar_v) chk("ar_hold", 64'({axi.arvalid, axi.araddr}), 64'({1'b1, p_ar_addr}));
        if (p_b_hs) chk("bready_drop", 64'(axi.bready), 64'd0);
        if (p_r_hs) chk("rready_drop", 64'(axi.rready), 64'd0);
        if (p_rsp_v && !p_rsp_rdy)
          chk("rsp_hold", 64'({rsp_valid, rsp_is_wr, rsp_resp, rsp_rdata}),
              64'({1'b1, p_rsp_wr, p_rsp_resp, p_rsp_data}));
        if (p_rsp_v && p_rsp_rdy) chk("rsp_drop", 64'(rsp_valid), 64'd0);
      end
      if (rst_n) begin
        if (axi.awvalid && axi.awready) begin aw_n++; aw_addr_c = axi.awaddr; end
        if (axi.wvalid && axi.wready) begin w_n++; w_data_c = axi.wdata; w_strb_c = axi.wstrb; end
        if (axi.bvalid && axi.bready) b_n++;
        if (axi.arvalid && axi.arready) begin ar_n++; ar_addr_c = axi.araddr; end
        if (axi.rvalid && axi.rready) r_n++;
      end
      p_aw_v = axi.awvalid; p_aw_hs = axi.awvalid && axi.awready; p_aw_addr = axi.awaddr;
      p_w_v = axi.wvalid;   p_w_hs = axi.wvalid && axi.wready;    p_w_data = axi.wdata;
      p_ar_v = axi.arvalid; p_ar_hs = axi.arvalid && axi.arready; p_ar_addr = axi.araddr;
      p_b_hs = axi.bvalid && axi.bready;
      p_r_hs = axi.rvalid && axi.rready;
      p_rsp_v = rsp_valid; p_rsp_rdy = rsp_ready; p_rsp_wr = rsp_is_wr;
      p_rsp_resp = rsp_resp; p_rsp_data = rsp_rdata;
      p_rst = rst_n;
    end
  end

  // Falling-edge slave: readies after a programmable wait, B/R after the
  // request side completes, held until consumed.
  initial begin
    int aw_w, w_w, ar_w, b_w, r_w;
    aw_w = 0; w_w = 0; ar_w = 0; b_w = 0; r_w = 0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
    axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
        axi.bvalid = 1'b0; axi.rvalid = 1'b0;
        aw_w = 0; w_w = 0; ar_w = 0; b_w = 0; r_w = 0;
      end else begin
        if (!axi.awvalid) begin aw_w = 0; axi.awready = 1'b0; end
        else if (aw_w >= aw_dly) axi.awready = 1'b1;
        else begin aw_w++; axi.awready = 1'b0; end
        if (!axi.wvalid) begin w_w = 0; axi.wready = 1'b0; end
        else if (w_w >= w_dly) axi.wready = 1'b1;
        else begin w_w++; axi.wready = 1'b0; end
        if (!axi.arvalid) begin ar_w = 0; axi.arready = 1'b0; end
        else if (ar_w >= ar_dly) axi.arready = 1'b1;
        else begin ar_w++; axi.arready = 1'b0; end
        if (axi.bvalid) begin
          if (b_n == aw_n) axi.bvalid = 1'b0;
        end else if (aw_n == w_n && aw_n > b_n) begin
          if (b_w >= b_dly) begin
            b_w = 0;
            axi.bvalid = 1'b1;
            axi.bresp = bresp_cfg;
            if (bresp_cfg == 2'b00)
              smem[aw_addr_c[3:2]] = apply_strb(smem[aw_addr_c[3:2]], w_data_c, w_strb_c);
          end else b_w++;
        end
        if (axi.rvalid) begin
          if (r_n == ar_n) axi.rvalid = 1'b0;
        end else if (ar_n > r_n) begin
          if (r_w >= r_dly) begin
            r_w = 0;
            axi.rvalid = 1'b1;
            axi.rdata = smem[ar_addr_c[3:2]];
            axi.rresp = rresp_cfg;
          end else r_w++;
        end
      end
    end
  end

  task automatic set_dly(input int aw, input int w, input int ar, input int b, input int r);
    aw_dly = aw; w_dly = w; ar_dly = ar; b_dly = b; r_dly = r;
  endtask

  // One command end to end; call and return on a falling edge.
  task automatic do_cmd(input logic we, input logic [AW-1:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input int hold, output int lat);
    int aw0, w0, b0, ar0, r0, t;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    aw0 = aw_n; w0 = w_n; b0 = b_n; ar0 = ar_n; r0 = r_n;
    lat = -1;
    if (we) begin
      exp_rdata = 32'h0;
      exp_resp  = bresp_cfg;
      if (bresp_cfg == 2'b00) ref_mem[addr[3:2]] = apply_strb(ref_mem[addr[3:2]], wd, ws);
    end else begin
      exp_rdata = ref_mem[addr[3:2]];
      exp_resp  = rresp_cfg;
    end
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    t = 0;
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin
      chk("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("valid_after_accept", 64'({axi.awvalid, axi.wvalid, axi.arvalid}),
        we ? 64'b110 : 64'b001);
    chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
    t = 0;
    while (!rsp_valid && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) begin
      chk("rsp_timeout", 64'(rsp_valid), 64'd1);
      return;
    end
    lat = t;
    for (int i = 0; i < hold; i++) begin
      chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      @(negedge clk);
    end
    chk("rsp_is_wr", 64'(rsp_is_wr), 64'(we));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
    chk("rsp_resp", 64'(rsp_resp), 64'(exp_resp));
    if (we) begin
      chk("wr_hs_counts", 64'({8'(aw_n - aw0), 8'(w_n - w0), 8'(b_n - b0), 8'(ar_n - ar0)}),
          64'h01010100);
      chk("wr_payload", 64'({aw_addr_c, w_strb_c, w_data_c}), 64'({addr, ws, wd}));
    end else begin
      chk("rd_hs_counts", 64'({8'(aw_n - aw0), 8'(ar_n - ar0), 8'(r_n - r0)}), 64'h000101);
      chk("rd_addr", 64'(ar_addr_c), 64'(addr));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_done_valid", 64'(rsp_valid), 64'd0);
    chk("rsp_done_cmd_ready", 64'(cmd_ready), 64'd1);
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("cmd_ready_edge1", 64'(cmd_ready), 64'd0);
    @(posedge clk);
    #1 chk("cmd_ready_edge2", 64'(cmd_ready), 64'd1);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, pick;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    set_dly(0, 0, 0, 0, 0);
    bresp_cfg = 2'b00; rresp_cfg = 2'b00;
    for (int i = 0; i < 4; i++) begin
      smem[i] = 32'h1111_1111 * (i + 1);
      ref_mem[i] = 32'h1111_1111 * (i + 1);
    end
    smem[2] = 32'hABCDEF01; ref_mem[2] = 32'hABCDEF01;

    repeat (3) @(negedge clk);
    chk("rst_valids", 64'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}), 64'd0);
    chk("rst_cmd_rsp", 64'({cmd_ready, rsp_valid, rsp_is_wr, rsp_resp}), 64'd0);
    chk("rst_data", 64'({rsp_rdata, axi.wdata}), 64'd0);
    chk("rst_addr_strb", 64'({axi.awaddr, axi.wstrb}), 64'd0);
    chk("prot", 64'({axi.awprot, axi.arprot}), 64'd0);
    release_reset();

    // Write with AW/W ready together, OKAY; minimum latency.
    do_cmd(1'b1, 4'h4, 32'h87654321, 4'hF, 0, lat);
    chk("wr_min_latency", 64'(lat), 64'd2);
    // Read with zero slave delay: minimum latency and write-back data.
    do_cmd(1'b0, 4'h4, 32'h0, 4'h0, 0, lat);
    chk("rd_min_latency", 64'(lat), 64'd2);
    // Read with three wait cycles on AR and R.
    set_dly(0, 0, 3, 0, 3);
    do_cmd(1'b0, 4'h8, 32'h0, 4'h0, 1, lat);
    // W handshake two cycles ahead of AW.
    set_dly(2, 0, 0, 0, 0);
    do_cmd(1'b1, 4'h0, 32'h5A5A_C3C3, 4'h5, 0, lat);
    // AW ahead of W, slow B.
    set_dly(0, 3, 0, 2, 0);
    do_cmd(1'b1, 4'h0, 32'hFFFF_0000, 4'hC, 0, lat);
    // SLVERR on write, response held before acceptance.
    set_dly(0, 0, 0, 0, 0);
    bresp_cfg = 2'b10;
    do_cmd(1'b1, 4'h8, 32'hDEAD_BEEF, 4'hF, 3, lat);
    bresp_cfg = 2'b00;
    // DECERR on read with a 5-cycle stalled response.
    rresp_cfg = 2'b11;
    do_cmd(1'b0, 4'h0, 32'h0, 4'h0, 5, lat);
    rresp_cfg = 2'b00;

    for (int n = 0; n < 40; n++) begin
      set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
      pick = $urandom_range(0, 3);
      bresp_cfg = (pick == 1) ? 2'b00 : 2'(pick);
      pick = $urandom_range(0, 3);
      rresp_cfg = (pick == 1) ? 2'b00 : 2'(pick);
      do_cmd(1'($urandom_range(0, 1)), {2'($urandom_range(0, 3)), 2'b00}, $urandom,
             4'($urandom_range(0, 15)), $urandom_range(0, 3), lat);
    end
    bresp_cfg = 2'b00; rresp_cfg = 2'b00;

    // Reset while awvalid is pending: the write is dropped.
    set_dly(20, 20, 0, 0, 0);
    chk("pre_abort_ready", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 4'h4; cmd_wdata = 32'h0BAD_0BAD; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("abort_awvalid_up", 64'(axi.awvalid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_valids_low", 64'({axi.awvalid, axi.wvalid, axi.arvalid, rsp_valid}), 64'd0);
    chk("abort_cmd_ready", 64'(cmd_ready), 64'd0);
    repeat (2) @(negedge clk);
    set_dly(0, 0, 0, 0, 0);
    release_reset();
    do_cmd(1'b1, 4'hC, 32'h10FEDCBA, 4'hF, 0, lat);
    do_cmd(1'b0, 4'hC, 32'h0, 4'h0, 0, lat);
    do_cmd(1'b0, 4'h4, 32'h0, 4'h0, 0, lat);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
